md_iter_div: RTL and testbench
==============================

Name: md_iter_div

Overview:
- Iterative radix-2 restoring divider used by the E-stage HI/LO multiply-divide unit for div/divu, replacing its single-cycle behavioural divide.
- The HI/LO unit issues a start with both operands, then waits for done. On done it writes quotient to LO and remainder to HI, unless div_zero is set, in which case HI/LO keep their values.
- The divider is abortable so an exception or interrupt request (req) can cancel an in-flight division without side effects.

Parameters:
- WIDTH, 32, operand/result width in bits (iteration count equals WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
- start  input  1  launch request. Accepted only in IDLE.
- is_signed  input  1  1 = div (two's complement), 0 = divu. Sampled with start.
- dividend  input  WIDTH  A operand (GPR rs). Sampled with start.
- divisor  input  WIDTH  B operand (GPR rt). Sampled with start.
- abort  input  1  cancel, driven from req.
- busy  output  1  1 while a division is in flight.
- done  output  1  one-cycle pulse: quotient/remainder/div_zero are final.
- quotient  output  WIDTH  result for LO. Held until the next done.
- remainder  output  WIDTH  result for HI. Held until the next done.
- div_zero  output  1  set with done when divisor was 0. Held until the next done.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, div_zero=0, quotient=0, remainder=0.
  - Reset has priority over everything, including mid-operation: the iteration is discarded and no done is produced.
- States: IDLE, CALC, FIX, ZERO.
- IDLE:
  - abort=1 → stay IDLE; start is ignored (abort wins over a simultaneous start).
  - Otherwise start=1 at edge E0 → latch operands and is_signed, busy<=1.
  - Divisor==0 → go to ZERO.
  - Otherwise:
    - Load the magnitudes |dividend| and |divisor| (raw values when unsigned).
    - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
    - count<=0, go to CALC.
- CALC: each edge performs one step.
  - Shift {partial remainder, working quotient} left by 1.
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and set quotient bit 0 to 1.
  - count increments each step. After WIDTH steps (edges E1..E32 for WIDTH=32) go to FIX.
- FIX (edge E33):
  - Negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Drive quotient/remainder, done<=1, busy<=0, div_zero<=0, go to IDLE.
  - Total latency: done is visible in the cycle after the 33rd edge following E0, and busy is high for exactly 33 cycles.
- ZERO (edge E1):
  - done<=1, div_zero<=1, busy<=0, go to IDLE.
  - quotient and remainder are NOT modified.
- done lasts exactly one cycle and deasserts on the next edge.
- A new start is legal in the same cycle done is high, since the state is already IDLE.
- start while busy=1 is ignored; the operands are not re-sampled.
- abort=1 while in CALC, FIX or ZERO:
  - Next edge → IDLE, busy<=0, no done.
  - quotient/remainder/div_zero keep their previous values.
- Arithmetic rules:
  - Truncation toward zero; the remainder takes the dividend's sign (MIPS semantics).
  - Magnitude of -2^(WIDTH-1) is handled as an unsigned 2^(WIDTH-1) with no overflow in CALC.
  - Signed -2^31 / -1 → quotient 0x80000000, remainder 0 (two's complement wrap, no trap).
- Operand inputs may change freely after E0; only the latched copies are used.

Test Plan:
- divu 100/7 (start at E0) → busy=1 for 33 cycles; done pulse after E33 with quotient=0x0000000E, remainder=0x00000002, div_zero=0.
- div -7/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then div 7/-2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- Edge values:
  - divu 0xFFFFFFFF/0x10 → quotient=0x0FFFFFFF, remainder=0xF.
  - div 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: after the 100/7 result, div 5/0 → done after E1 with div_zero=1; quotient stays 0xE and remainder stays 0x2.
- Abort and start interactions:
  - abort at E10 of 100/7 → busy=0 after E11, no done for 40 cycles, outputs unchanged.
  - Retry 9/3 → quotient=3, remainder=0.
  - start+abort in the same IDLE cycle → no launch.
  - start pulse during busy → ignored, the original result is delivered.
- reset=0 at E20 → all outputs 0, no done. Back-to-back: start asserted in the done cycle → the second result arrives 33 edges later.

Source files
------------

// File: rtl/md_iter_div_if.sv
// Start/result handshake between the HI/LO unit (master) and the iterative divider (slave).
interface md_iter_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor, abort,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, abort,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/md_iter_div.sv
// Abortable radix-2 restoring divider for div/divu: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up cycle.
module md_iter_div #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    md_iter_div_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StZero} state_e;

    state_e           r_state;
    logic [CntW-1:0]  r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_b_neg = bus.is_signed & bus.divisor[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
    assign w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_mag = w_b_neg ? -bus.divisor : bus.divisor;

    // Partial remainder stays below the divisor, so one extra bit covers the shifted trial value.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_fits     = ~w_diff[WIDTH];
    assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != StIdle && bus.abort) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (bus.start && !bus.abort) begin
                            r_busy <= 1'b1;
                            if (bus.divisor == '0) begin
                                r_state <= StZero;
                            end else begin
                                r_rem   <= '0;
                                r_quo   <= w_a_mag;
                                r_dvs   <= w_b_mag;
                                r_q_neg <= w_a_neg ^ w_b_neg;
                                r_r_neg <= w_a_neg;
                                r_count <= '0;
                                r_state <= StCalc;
                            end
                        end
                    end
                    StCalc: begin
                        r_rem   <= w_rem_next;
                        r_quo   <= w_quo_next;
                        r_count <= r_count + 1'b1;
                        if (r_count == CntW'(WIDTH - 1)) begin
                            r_state <= StFix;
                        end
                    end
                    StFix: begin
                        r_quotient  <= r_q_neg ? -r_quo : r_quo;
                        r_remainder <= r_r_neg ? -r_rem : r_rem;
                        r_div_zero  <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                    StZero: begin
                        r_div_zero <= 1'b1;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= StIdle;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_md_iter_div.sv
// Self-checking bench for md_iter_div: vector table and random ops through a result scoreboard,
// plus hand sequences for abort, reset, start collisions and timing.
module tb_md_iter_div;
    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          edges;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_dz = 1'b0;
    vec_t vecs[7];

    md_iter_div_if #(.WIDTH(32)) bus ();

    md_iter_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result from the language's own signed/unsigned division operators.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dz,
                          input int edges, input bit push);
        exp_t e;
        if (push) begin
            e.q = q; e.r = r; e.dz = dz; e.edges = edges;
            sb.push_back(e);
            last_q = q; last_r = r; last_dz = dz;
        end
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        step();
        bus.start     = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    task automatic wait_done(input string name);
        int   edges = 0;
        int   busy_cnt = 0;
        exp_t e;
        while (!bus.done && edges < 60) begin
            if (bus.busy) busy_cnt++;
            step();
            edges++;
        end
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({name, "_done_seen"}, {31'd0, bus.done}, 32'd1);
        if (!bus.done) return;
        chk({name, "_latency"}, edges, e.edges);
        chk({name, "_busy_cycles"}, busy_cnt, e.edges);
        chk({name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
        chk({name, "_quotient"}, bus.quotient, e.q);
        chk({name, "_remainder"}, bus.remainder, e.r);
        chk({name, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, e.dz});
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            step();
            if (bus.done) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic check_held(input string name);
        chk({name, "_q_held"}, bus.quotient, last_q);
        chk({name, "_r_held"}, bus.remainder, last_r);
        chk({name, "_dz_held"}, {31'd0, bus.div_zero}, {31'd0, last_dz});
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;

        vecs[0] = '{1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0};
        vecs[1] = '{1'b1, 32'd5, 32'd0, 32'h0000_000E, 32'h0000_0002, 1'b1};
        vecs[2] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0};

        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        bus.abort = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        step();

        // Table vectors run back-to-back: each start is driven in the done cycle of the previous.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                   vecs[i].dz ? 1 : 33, 1'b1);
            wait_done($sformatf("vec%0d", i));
        end
        step();
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 0) rb = 32'd3;
            model(rs, ra, rb, rq, rr);
            launch(rs, ra, rb, rq, rr, 1'b0, 33, 1'b1);
            wait_done($sformatf("rand%0d", i));
        end
        step();

        // Abort sampled at E11 of a 100/7.
        launch(1'b0, 32'd100, 32'd7, '0, '0, 1'b0, 0, 1'b0);
        repeat (10) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy_low", {31'd0, bus.busy}, 32'd0);
        expect_quiet("abort_no_done", 40);
        check_held("abort");

        launch(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 1'b1);
        wait_done("retry_9_3");
        step();

        bus.start = 1'b1; bus.abort = 1'b1; bus.is_signed = 1'b0;
        bus.dividend = 32'd100; bus.divisor = 32'd7;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_no_launch", {31'd0, bus.busy}, 32'd0);
        expect_quiet("start_abort_no_done", 40);
        check_held("start_abort");

        // A second start while busy must not re-sample operands.
        launch(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, 27, 1'b1);
        repeat (5) step();
        bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1;
        step();
        bus.start = 1'b0;
        wait_done("start_while_busy");
        step();

        // Synchronous reset sampled at E20 discards the division.
        launch(1'b0, 32'd100, 32'd7, '0, '0, 1'b0, 0, 1'b0);
        repeat (19) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_quotient", bus.quotient, 32'd0);
        chk("midrst_remainder", bus.remainder, 32'd0);
        chk("midrst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        expect_quiet("midrst_no_done", 40);

        launch(1'b1, 32'hFFFF_FFF7, 32'd3, 32'hFFFF_FFFD, 32'd0, 1'b0, 33, 1'b1);
        wait_done("post_reset_a");
        launch(1'b0, 32'd50, 32'd0, 32'hFFFF_FFFD, 32'd0, 1'b1, 1, 1'b1);
        wait_done("post_reset_zero");
        launch(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33, 1'b1);
        wait_done("post_reset_b2b");
        step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
